// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared register map, bit indices, FSM states and CRC7 step for the SD CMD sequencer
package sd_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_ARG     = 3'd1;
  localparam logic [2:0] ADDR_CLKCFG  = 3'd2;
  localparam logic [2:0] ADDR_RESP_LO = 3'd3;
  localparam logic [2:0] ADDR_RESP_HI = 3'd4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_RESP_EN  = 16;
  localparam int CTRL_CRC_CHK  = 17;
  localparam int CTRL_IRQ_EN   = 18;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_TIMEOUT  = 2;
  localparam int STAT_CRC_ERR  = 3;

  localparam int CLKCFG_EN     = 31;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT_RESP,
    ST_RX,
    ST_GAP
  } sd_state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1), MSB first; clr together with en restarts from zero
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (en) begin
      crc_d = crc7_step(clr ? 7'h00 : crc_q, bit_in);
    end else if (clr) begin
      crc_d = 7'h00;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD CMD-line sequencer: SD_CLK divider, CRC7 command TX, response capture
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter logic [7:0] CLKDIV_RST = 8'd124,
  parameter int         RESP_TMO   = 64,
  parameter int         GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        sd_clk,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  input  logic        sd_cmd_in
);

  sd_state_e   state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d, crc_err_q, crc_err_d;
  logic [5:0]  cmd_idx_q, cmd_idx_d;
  logic        resp_en_q, resp_en_d, crc_chk_q, crc_chk_d, irq_en_q, irq_en_d;
  logic [31:0] arg_q, arg_d;
  logic [7:0]  clkdiv_q, clkdiv_d, div_cnt_q, div_cnt_d;
  logic        clk_en_q, clk_en_d, sd_clk_q, sd_clk_d;
  logic [47:0] shift_q, shift_d, resp_q, resp_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        cmd_out_q, cmd_out_d, cmd_oe_q, cmd_oe_d;
  logic        cmd_meta_q, cmd_meta_d, cmd_sync_q, cmd_sync_d;

  logic        wr_en, fall_stb, rise_stb;
  logic [47:0] frame;
  logic        tx_crc_clr, tx_crc_en, tx_crc_bit, rx_crc_clr, rx_crc_en, rx_crc_bit;
  logic [6:0]  tx_crc, rx_crc;
  logic        unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign cmd_meta_d   = sd_cmd_in;
  assign cmd_sync_d   = cmd_meta_q;
  assign frame        = {2'b01, cmd_idx_q, arg_q, 7'h00, 1'b1};
  assign unused_wdata = ^{writedata[30:19], writedata[15:14]};

  sd_crc7 u_tx_crc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (tx_crc_clr),
    .en     (tx_crc_en),
    .bit_in (tx_crc_bit),
    .crc    (tx_crc)
  );

  sd_crc7 u_rx_crc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (rx_crc_clr),
    .en     (rx_crc_en),
    .bit_in (rx_crc_bit),
    .crc    (rx_crc)
  );

  // Half-period counter; strobes mark the clk cycle whose edge flips sd_clk.
  always_comb begin
    div_cnt_d = div_cnt_q;
    sd_clk_d  = sd_clk_q;
    fall_stb  = 1'b0;
    rise_stb  = 1'b0;
    if (!clk_en_q) begin
      div_cnt_d = clkdiv_q;
      sd_clk_d  = 1'b0;
    end else if (div_cnt_q == 8'd0) begin
      div_cnt_d = clkdiv_q;
      sd_clk_d  = ~sd_clk_q;
      fall_stb  = sd_clk_q;
      rise_stb  = ~sd_clk_q;
    end else begin
      div_cnt_d = div_cnt_q - 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    crc_err_d  = crc_err_q;
    cmd_idx_d  = cmd_idx_q;
    resp_en_d  = resp_en_q;
    crc_chk_d  = crc_chk_q;
    irq_en_d   = irq_en_q;
    arg_d      = arg_q;
    clkdiv_d   = clkdiv_q;
    clk_en_d   = clk_en_q;
    shift_d    = shift_q;
    resp_d     = resp_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    cmd_out_d  = cmd_out_q;
    cmd_oe_d   = cmd_oe_q;
    tx_crc_clr = (state_q == ST_IDLE);
    tx_crc_en  = 1'b0;
    tx_crc_bit = shift_q[47];
    rx_crc_clr = (state_q == ST_WAIT_RESP);
    rx_crc_en  = 1'b0;
    rx_crc_bit = cmd_sync_q;

    if (wr_en) begin
      case (address)
        ADDR_CTRL: begin
          irq_en_d = writedata[CTRL_IRQ_EN];
          if (writedata[CTRL_CLR_DONE]) done_d = 1'b0;
          if (writedata[CTRL_START] && !busy_q) begin
            busy_d    = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            cmd_idx_d = writedata[13:8];
            resp_en_d = writedata[CTRL_RESP_EN];
            crc_chk_d = writedata[CTRL_CRC_CHK];
          end
        end
        ADDR_ARG: arg_d = writedata;
        ADDR_CLKCFG: begin
          clkdiv_d = writedata[7:0];
          clk_en_d = writedata[CLKCFG_EN];
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (busy_q && fall_stb) begin
          cmd_out_d  = frame[47];
          cmd_oe_d   = 1'b1;
          shift_d    = {frame[46:0], 1'b0};
          bit_cnt_d  = 6'd1;
          tx_crc_en  = 1'b1;
          tx_crc_bit = frame[47];
          state_d    = ST_TX;
        end
      end
      ST_TX: begin
        if (fall_stb) begin
          if (bit_cnt_q == 6'd48) begin
            cmd_oe_d   = 1'b0;
            cmd_out_d  = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = resp_en_q ? ST_WAIT_RESP : ST_GAP;
          end else if (bit_cnt_q == 6'd40) begin
            // Header+arg are all out: splice the finished CRC in ahead of the end bit.
            cmd_out_d = tx_crc[6];
            shift_d   = {tx_crc[5:0], 1'b1, 41'h0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            cmd_out_d = shift_q[47];
            tx_crc_en = (bit_cnt_q < 6'd40);
            shift_d   = {shift_q[46:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (rise_stb) begin
          if (!cmd_sync_q) begin
            rx_crc_en = 1'b1;
            resp_d    = 48'h0;
            bit_cnt_d = 6'd1;
            state_d   = ST_RX;
          end else if (wait_cnt_q == 8'(RESP_TMO - 1)) begin
            timeout_d  = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = ST_GAP;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ST_RX: begin
        if (rise_stb) begin
          resp_d    = {resp_q[46:0], cmd_sync_q};
          rx_crc_en = (bit_cnt_q < 6'd40);
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd47) begin
            // resp_q[6:0] already holds response bits [7:1]; the end bit arrives now.
            if (crc_chk_q && (rx_crc != resp_q[6:0])) crc_err_d = 1'b1;
            wait_cnt_d = 8'd0;
            state_d    = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (rise_stb) begin
          if (wait_cnt_q == 8'(GAP_CYCLES - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      cmd_idx_q  <= 6'd0;
      resp_en_q  <= 1'b0;
      crc_chk_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      arg_q      <= 32'h0;
      clkdiv_q   <= CLKDIV_RST;
      clk_en_q   <= 1'b0;
      div_cnt_q  <= CLKDIV_RST;
      sd_clk_q   <= 1'b0;
      shift_q    <= 48'h0;
      resp_q     <= 48'h0;
      bit_cnt_q  <= 6'd0;
      wait_cnt_q <= 8'd0;
      cmd_out_q  <= 1'b1;
      cmd_oe_q   <= 1'b0;
      cmd_meta_q <= 1'b1;
      cmd_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      crc_err_q  <= crc_err_d;
      cmd_idx_q  <= cmd_idx_d;
      resp_en_q  <= resp_en_d;
      crc_chk_q  <= crc_chk_d;
      irq_en_q   <= irq_en_d;
      arg_q      <= arg_d;
      clkdiv_q   <= clkdiv_d;
      clk_en_q   <= clk_en_d;
      div_cnt_q  <= div_cnt_d;
      sd_clk_q   <= sd_clk_d;
      shift_q    <= shift_d;
      resp_q     <= resp_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      cmd_out_q  <= cmd_out_d;
      cmd_oe_q   <= cmd_oe_d;
      cmd_meta_q <= cmd_meta_d;
      cmd_sync_q <= cmd_sync_d;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_CTRL: begin
        readdata[STAT_BUSY]    = busy_q;
        readdata[STAT_DONE]    = done_q;
        readdata[STAT_TIMEOUT] = timeout_q;
        readdata[STAT_CRC_ERR] = crc_err_q;
        readdata[13:8]         = cmd_idx_q;
      end
      ADDR_ARG:     readdata = arg_q;
      ADDR_CLKCFG:  readdata = {clk_en_q, 23'h0, clkdiv_q};
      ADDR_RESP_LO: readdata = resp_q[39:8];
      ADDR_RESP_HI: readdata = {24'h0, resp_q[47:40]};
      default:      readdata = 32'h0;
    endcase
  end

  assign irq        = done_q & irq_en_q;
  assign sd_clk     = sd_clk_q;
  assign sd_cmd_out = cmd_out_q;
  assign sd_cmd_oe  = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - randomized self-checking bench with a frame-level SD card/host reference model
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq, sd_clk, sd_cmd_out, sd_cmd_oe;
  logic        sd_cmd_in = 1'b1;

  int checks = 0;
  int failures = 0;

  sd_cmd_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .sd_clk    (sd_clk),
    .sd_cmd_out(sd_cmd_out),
    .sd_cmd_oe (sd_cmd_oe),
    .sd_cmd_in (sd_cmd_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of long division of data*x^7 by x^7+x^3+1.
  function automatic logic [6:0] model_crc7(input logic [39:0] data);
    logic [46:0] r;
    r = {data, 7'h00};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] model_frame(input logic [1:0] hdr, input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {hdr, idx, arg};
    return {body, model_crc7(body), 1'b1};
  endfunction

  function automatic logic [31:0] model_status(input bit busy, input bit done, input bit tmo,
                                               input bit crc_err, input logic [5:0] idx);
    return {18'h0, idx, 4'h0, crc_err, tmo, done, busy};
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1 d = readdata;
  endtask

  // Watches one transaction until done; records host bits at sd_clk rises while oe=1,
  // counts rises after the host releases the line, and optionally plays a card reply
  // starting at the delay-th sd_clk fall after release.
  task automatic run_txn(input bit reply, input logic [47:0] resp_frame, input int delay,
                         input bit mid_arg, input logic [31:0] new_arg,
                         output logic [47:0] tx_bits, output int ntx, output int rises_after,
                         output bit expired);
    bit prev_clk, prev_oe, rise, fall, released;
    int falls, rb, wr_phase;
    tx_bits = 48'h0; ntx = 0; rises_after = 0; expired = 1'b1;
    falls = 0; rb = 0; wr_phase = 0; released = 1'b0;
    address = 3'd0;
    prev_clk = sd_clk; prev_oe = sd_cmd_oe;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      rise = sd_clk & ~prev_clk;
      fall = ~sd_clk & prev_clk;
      if (rise && sd_cmd_oe) begin
        tx_bits = {tx_bits[46:0], sd_cmd_out};
        ntx++;
      end
      if (rise && released) rises_after++;
      if (fall && released && reply) begin
        falls++;
        if (falls >= delay && rb < 48) begin
          sd_cmd_in = resp_frame[47 - rb];
          rb++;
        end else if (rb >= 48) begin
          sd_cmd_in = 1'b1;
        end
      end
      if (prev_oe && !sd_cmd_oe) released = 1'b1;
      if (address == 3'd0 && readdata[1]) begin
        expired = 1'b0;
        break;
      end
      if (wr_phase == 1) begin
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; wr_phase = 2;
      end else if (mid_arg && wr_phase == 0 && ntx == 10) begin
        address = 3'd1; writedata = new_arg; chipselect = 1'b1; write_n = 1'b0; wr_phase = 1;
      end
      prev_clk = sd_clk; prev_oe = sd_cmd_oe;
    end
    sd_cmd_in = 1'b1;
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
  endtask

  task automatic measure_clk(output int period, output int high);
    bit p;
    period = 0; high = 0;
    p = sd_clk;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (sd_clk && !p) break;
      p = sd_clk;
    end
    p = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      period++;
      if (sd_clk) high++;
      if (sd_clk && !p) break;
      p = sd_clk;
    end
  endtask

  logic [31:0] rd;
  logic [47:0] txb, rframe, exp_resp;
  int          ntx, rises, per, hi, dly, mode;
  bit          expd, resp_en, crc_chk, irq_en, corrupt, silent, exp_crc_err;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic [7:0]  cdiv;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_oe_during", sd_cmd_oe, 0);
    reset_n = 1'b1;

    check("rst_sd_clk", sd_clk, 0);
    check("rst_cmd_out", sd_cmd_out, 1);
    check("rst_irq", irq, 0);
    bus_read(3'd0, rd); check("rst_status", rd, 0);
    bus_read(3'd1, rd); check("rst_arg", rd, 0);
    bus_read(3'd2, rd); check("rst_clkcfg", rd, 32'h0000007C);
    bus_read(3'd3, rd); check("rst_resp_lo", rd, 0);
    bus_read(3'd4, rd); check("rst_resp_hi", rd, 0);
    bus_read(3'd6, rd); check("rd_addr6", rd, 0);
    bus_write(3'd6, 32'hFFFFFFFF);
    bus_read(3'd6, rd); check("wr_addr6_ignored", rd, 0);

    bus_write(3'd2, 32'h80000001);
    measure_clk(per, hi); check("clk_div1_period", per, 4); check("clk_div1_high", hi, 2);
    bus_write(3'd2, 32'h80000003);
    measure_clk(per, hi);
    measure_clk(per, hi); check("clk_div3_period", per, 8); check("clk_div3_high", hi, 4);

    // CMD0, no response
    bus_write(3'd1, 32'h0);
    bus_write(3'd0, 32'h001);
    run_txn(0, 48'h0, 0, 0, 0, txb, ntx, rises, expd);
    check("cmd0_expired", expd, 0);
    check("cmd0_tx", txb, 48'h400000000095);
    check("cmd0_nbits", ntx, 48);
    check("cmd0_gap", rises, 8);
    bus_read(3'd0, rd); check("cmd0_status", rd, model_status(0, 1, 0, 0, 6'd0));
    check("cmd0_irq", irq, 0);

    // CMD8 with R7 reply
    bus_write(3'd1, 32'h1AA);
    bus_write(3'd0, 32'h70801);
    run_txn(1, 48'h08000001AA13, 5, 0, 0, txb, ntx, rises, expd);
    check("cmd8_expired", expd, 0);
    check("cmd8_tx", txb, 48'h48000001AA87);
    check("cmd8_resp_span", rises, 5 + 56);
    bus_read(3'd3, rd); check("cmd8_resp_lo", rd, 32'h000001AA);
    bus_read(3'd4, rd); check("cmd8_resp_hi", rd, 32'h08);
    bus_read(3'd0, rd); check("cmd8_status", rd, model_status(0, 1, 0, 0, 6'd8));
    check("cmd8_irq", irq, 1);

    bus_write(3'd0, 32'h70801);
    run_txn(0, 48'h0, 0, 0, 0, txb, ntx, rises, expd);
    check("tmo_span", rises, 72);
    bus_read(3'd0, rd); check("tmo_status", rd, model_status(0, 1, 1, 0, 6'd8));
    bus_read(3'd3, rd); check("tmo_resp_kept", rd, 32'h000001AA);

    bus_write(3'd0, 32'h70801);
    run_txn(1, 48'h08000001AA13 ^ 48'h4, 3, 0, 0, txb, ntx, rises, expd);
    bus_read(3'd0, rd); check("crc_bad_status", rd, model_status(0, 1, 0, 1, 6'd8));

    bus_write(3'd0, 32'h50801);
    run_txn(1, 48'h08000001AA13 ^ 48'h4, 3, 0, 0, txb, ntx, rises, expd);
    bus_read(3'd0, rd); check("crc_skip_status", rd, model_status(0, 1, 0, 0, 6'd8));

    // Busy-start ignored, ARG during TX only affects the next command
    bus_write(3'd2, 32'h00000003);
    bus_write(3'd1, 32'h12345678);
    bus_write(3'd0, 32'h00000501);
    bus_read(3'd0, rd); check("stall_busy", rd, model_status(1, 0, 0, 0, 6'd5));
    bus_write(3'd0, 32'h00003F01);
    bus_read(3'd0, rd); check("busy_start_ignored", rd, model_status(1, 0, 0, 0, 6'd5));
    bus_write(3'd2, 32'h80000003);
    run_txn(0, 48'h0, 0, 1, 32'hCAFEF00D, txb, ntx, rises, expd);
    check("busy_tx", txb, model_frame(2'b01, 6'd5, 32'h12345678));
    bus_read(3'd1, rd); check("arg_mid_write", rd, 32'hCAFEF00D);

    bus_write(3'd2, 32'h00000003);
    bus_write(3'd0, 32'h00000703);
    bus_read(3'd0, rd); check("start_clr_done", rd, model_status(1, 0, 0, 0, 6'd7));
    bus_write(3'd2, 32'h80000003);
    run_txn(0, 48'h0, 0, 0, 0, txb, ntx, rises, expd);
    check("next_arg_tx", txb, model_frame(2'b01, 6'd7, 32'hCAFEF00D));
    bus_write(3'd0, 32'h00040002);
    bus_read(3'd0, rd); check("clr_done", rd, model_status(0, 0, 0, 0, 6'd7));
    check("clr_done_irq", irq, 0);

    // Reset mid-TX
    bus_write(3'd0, 32'h00000101);
    for (int n = 0; n < 500 && !sd_cmd_oe; n++) @(negedge clk);
    check("pre_reset_oe", sd_cmd_oe, 1);
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_oe", sd_cmd_oe, 0);
    check("async_rst_cmd_out", sd_cmd_out, 1);
    check("async_rst_sd_clk", sd_clk, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd0, rd); check("post_rst_status", rd, 0);
    bus_read(3'd2, rd); check("post_rst_clkcfg", rd, 32'h0000007C);
    exp_resp = 48'h0;

    // Randomized commands against the frame-level model
    for (int t = 0; t < 10; t++) begin
      idx = 6'($urandom_range(0, 63));
      arg = $urandom;
      cdiv = 8'($urandom_range(2, 6));
      resp_en = 1'($urandom_range(0, 1));
      crc_chk = 1'($urandom_range(0, 1));
      irq_en = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      dly = $urandom_range(1, 20);
      corrupt = (mode == 1);
      silent = (mode == 2) || !resp_en;
      rframe = model_frame(2'b00, 6'($urandom_range(0, 63)), $urandom);
      if (corrupt) rframe = rframe ^ (48'h1 << $urandom_range(1, 7));
      exp_crc_err = resp_en && corrupt && crc_chk;
      bus_write(3'd2, {1'b1, 23'h0, cdiv});
      bus_write(3'd1, arg);
      bus_write(3'd0, {13'h0, irq_en, crc_chk, resp_en, 2'b00, idx, 8'h01});
      run_txn(!silent, rframe, dly, 0, 0, txb, ntx, rises, expd);
      check("rnd_expired", expd, 0);
      check("rnd_tx", txb, model_frame(2'b01, idx, arg));
      check("rnd_span", rises, !resp_en ? 8 : (mode == 2 ? 72 : dly + 56));
      if (resp_en && mode != 2) exp_resp = rframe;
      bus_read(3'd0, rd);
      check("rnd_status", rd, model_status(0, 1, resp_en && mode == 2, exp_crc_err, idx));
      bus_read(3'd3, rd); check("rnd_resp_lo", rd, exp_resp[39:8]);
      bus_read(3'd4, rd); check("rnd_resp_hi", rd, {24'h0, exp_resp[47:40]});
      check("rnd_irq", irq, irq_en);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
